ex_wb_stage: RTL

Execute-to-writeback pipeline stage that sits directly downstream of the ALU. It registers the ALU result and flag vector, holds the architectural NZCV status register, and evaluates the instruction's 4-bit condition code. Instructions whose condition fails are squashed, and each accepted instruction is presented to the register-file writeback port through a 2-entry skid buffer with a valid/ready handshake.

---
 rtl/ex_wb_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: condition-evaluating execute-to-writeback stage with NZCV register and 2-entry skid buffer
module ex_wb_stage #(
    parameter int WIDTH = 32,
    parameter int RA    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    input  logic [RA-1:0]    rd,
    input  logic             reg_write,
    input  logic             set_flags,
    input  logic             is_branch,
    input  logic [3:0]       cond,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] wb_result,
    output logic [RA-1:0]    wb_rd,
    output logic             wb_reg_write,
    output logic             wb_branch_taken,
    output logic [3:0]       flags_q
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RA-1:0]    rd;
        logic             wr;
        logic             br;
    } entry_t;

    state_t state, state_n;
    entry_t out_q, out_n, skid_q, skid_n, new_e;
    logic   base, pass, acc, pop;

    assign acc             = in_valid && in_ready && !flush;
    assign pop             = out_valid && out_ready;
    assign out_valid       = state != EMPTY;
    assign new_e           = {alu_result, rd, reg_write && pass, is_branch && pass};
    assign wb_result       = out_q.result;
    assign wb_rd           = out_q.rd;
    assign wb_reg_write    = out_q.wr;
    assign wb_branch_taken = out_q.br;

    // Odd condition codes are the negation of the preceding even code (AL/NV included)
    always_comb begin
        base = 1'b0;
        case (cond[3:1])
            3'd0: base = flags_q[2];
            3'd1: base = flags_q[1];
            3'd2: base = flags_q[3];
            3'd3: base = flags_q[0];
            3'd4: base = flags_q[1] && !flags_q[2];
            3'd5: base = flags_q[3] == flags_q[0];
            3'd6: base = !flags_q[2] && (flags_q[3] == flags_q[0]);
            default: base = 1'b1;
        endcase
        pass = base ^ cond[0];
    end

    // Skid-buffer occupancy and data movement; flush empties the buffer last so it overrides
    always_comb begin
        state_n = state;
        out_n   = out_q;
        skid_n  = skid_q;
        case (state)
            EMPTY: if (acc) begin
                state_n = ONE;
                out_n   = new_e;
            end
            ONE: if (acc && pop) begin
                out_n = new_e;
            end else if (acc) begin
                state_n = TWO;
                skid_n  = new_e;
            end else if (pop) begin
                state_n = EMPTY;
            end
            TWO: if (pop) begin
                state_n = ONE;
                out_n   = skid_q;
            end
            default: state_n = EMPTY;
        endcase
        if (flush) state_n = EMPTY;
    end

    // State, entries, registered ready and architectural flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            out_q    <= '0;
            skid_q   <= '0;
            flags_q  <= '0;
        end else begin
            state    <= state_n;
            in_ready <= state_n != TWO;
            out_q    <= out_n;
            skid_q   <= skid_n;
            if (acc && set_flags && pass) flags_q <= alu_flags;
        end
    end
endmodule
